// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with qualified forwarding outputs.
// Optional RETIRE_COUNT_EN adds a retired-instruction counter.
module ex_mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [REG_AW-1:0] ex_mem_rd,
  output logic              ex_mem_regwrite,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] ex_mem_store_data,
  output logic              ex_mem_memread,
  output logic              ex_mem_memwrite,
  output logic              ex_mem_is_load,
  output logic [REG_AW-1:0] mem_wb_rd,
  output logic              mem_wb_regwrite,
  output logic [DATA_W-1:0] mem_wb_wdata
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memtoreg;
    logic              memread;
    logic              memwrite;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sdata;
  } ex_mem_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic [DATA_W-1:0] wdata;
  } mem_wb_t;

  ex_mem_t em;
  mem_wb_t mw;

  // A flushed slot keeps its payload; only valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em <= '0;
    end else if (flush) begin
      em.valid <= 1'b0;
    end else if (!stall) begin
      em.valid    <= ex_valid;
      em.rd       <= ex_rd;
      em.regwrite <= ex_regwrite;
      em.memtoreg <= ex_memtoreg;
      em.memread  <= ex_memread;
      em.memwrite <= ex_memwrite;
      em.alu      <= ex_alu_result;
      em.sdata    <= ex_store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mw <= '0;
    end else begin
      if (stall) begin
        mw.valid <= 1'b0;
      end else begin
        mw.valid    <= em.valid;
        mw.rd       <= em.rd;
        mw.regwrite <= em.regwrite;
      end
      mw.wdata <= em.memtoreg ? mem_rdata : em.alu;
    end
  end

  logic em_rd_nz;
  logic mw_rd_nz;

  assign em_rd_nz = (em.rd != '0);
  assign mw_rd_nz = (mw.rd != '0);

  assign ex_mem_rd         = em.rd;
  assign ex_mem_regwrite   = em.valid & em.regwrite & em_rd_nz;
  assign ex_mem_alu_result = em.alu;
  assign ex_mem_store_data = em.sdata;
  assign ex_mem_memread    = em.valid & em.memread;
  assign ex_mem_memwrite   = em.valid & em.memwrite;
  assign ex_mem_is_load    = ex_mem_memread & em_rd_nz;

  assign mem_wb_rd       = mw.rd;
  assign mem_wb_regwrite = mw.valid & mw.regwrite & mw_rd_nz;
  assign mem_wb_wdata    = mw.wdata;

`ifdef RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (mw.valid) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Bench for ex_mem_wb_pipe: directed vector table, reset cases and
// randomized traffic against an instruction-level reference model.
module tb_ex_mem_wb_pipe;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memtoreg;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [31:0] mem_rdata;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regwrite;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_store_data;
  logic        ex_mem_memread;
  logic        ex_mem_memwrite;
  logic        ex_mem_is_load;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_regwrite;
  logic [31:0] mem_wb_wdata;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retire_cnt;
`endif

  ex_mem_wb_pipe #(.DATA_W(32), .REG_AW(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .flush             (flush),
    .ex_valid          (ex_valid),
    .ex_rd             (ex_rd),
    .ex_regwrite       (ex_regwrite),
    .ex_memtoreg       (ex_memtoreg),
    .ex_memread        (ex_memread),
    .ex_memwrite       (ex_memwrite),
    .ex_alu_result     (ex_alu_result),
    .ex_store_data     (ex_store_data),
    .mem_rdata         (mem_rdata),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_regwrite   (ex_mem_regwrite),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_memread    (ex_mem_memread),
    .ex_mem_memwrite   (ex_mem_memwrite),
    .ex_mem_is_load    (ex_mem_is_load),
    .mem_wb_rd         (mem_wb_rd),
    .mem_wb_regwrite   (mem_wb_regwrite),
    .mem_wb_wdata      (mem_wb_wdata)
`ifdef RETIRE_COUNT_EN
    ,
    .retire_cnt        (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Instruction-level reference: the op sitting in MEM and the op in WB.
  typedef struct {
    bit          live;
    logic [4:0]  rd;
    bit          wr;
    bit          ld_src;
    bit          rd_mem;
    bit          wr_mem;
    logic [31:0] addr;
    logic [31:0] sd;
  } mem_op_t;

  typedef struct {
    bit          live;
    logic [4:0]  rd;
    bit          wr;
    logic [31:0] val;
  } wb_op_t;

  mem_op_t     m_mem;
  wb_op_t      m_wb;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_mem = '{default: '0};
    m_wb  = '{default: '0};
    m_cnt = '0;
  endtask

  task automatic model_edge();
    mem_op_t incoming;
    if (m_wb.live) m_cnt = m_cnt + 32'd1;
    if (!stall) begin
      m_wb.live = m_mem.live;
      m_wb.rd   = m_mem.rd;
      m_wb.wr   = m_mem.wr;
    end else begin
      m_wb.live = 1'b0;
    end
    m_wb.val = m_mem.ld_src ? mem_rdata : m_mem.addr;
    incoming = '{live: ex_valid, rd: ex_rd, wr: ex_regwrite,
                 ld_src: ex_memtoreg, rd_mem: ex_memread,
                 wr_mem: ex_memwrite, addr: ex_alu_result,
                 sd: ex_store_data};
    if (flush) m_mem.live = 1'b0;
    else if (!stall) m_mem = incoming;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic model_check();
    bit e_rw, e_mw, e_mr, e_ld, w_rw;
    e_rw = m_mem.live && m_mem.wr && m_mem.rd != 0;
    e_mr = m_mem.live && m_mem.rd_mem;
    e_mw = m_mem.live && m_mem.wr_mem;
    e_ld = e_mr && m_mem.rd != 0;
    w_rw = m_wb.live && m_wb.wr && m_wb.rd != 0;
    chk("rnd ex_mem_regwrite", {31'd0, ex_mem_regwrite}, {31'd0, e_rw});
    chk("rnd ex_mem_memread", {31'd0, ex_mem_memread}, {31'd0, e_mr});
    chk("rnd ex_mem_memwrite", {31'd0, ex_mem_memwrite}, {31'd0, e_mw});
    chk("rnd ex_mem_is_load", {31'd0, ex_mem_is_load}, {31'd0, e_ld});
    chk("rnd mem_wb_regwrite", {31'd0, mem_wb_regwrite}, {31'd0, w_rw});
    if (e_rw) begin
      chk("rnd ex_mem_rd", {27'd0, ex_mem_rd}, {27'd0, m_mem.rd});
      chk("rnd ex_mem_alu", ex_mem_alu_result, m_mem.addr);
    end
    if (e_mw) chk("rnd ex_mem_store", ex_mem_store_data, m_mem.sd);
    if (w_rw) begin
      chk("rnd mem_wb_rd", {27'd0, mem_wb_rd}, {27'd0, m_wb.rd});
      chk("rnd mem_wb_wdata", mem_wb_wdata, m_wb.val);
    end
`ifdef RETIRE_COUNT_EN
    chk("rnd retire_cnt", retire_cnt, m_cnt);
`endif
  endtask

  typedef struct {
    logic        st, fl, v;
    logic [4:0]  rd;
    logic        rw, m2r, mr, mw;
    logic [31:0] alu, sd, rdat;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic        e_ld, e_mw;
    logic [31:0] e_sd;
    logic        w_rw;
    logic [4:0]  w_rd;
    logic [31:0] w_d;
  } vec_t;

  function automatic vec_t mk(
    input logic st, fl, v, input logic [4:0] rd,
    input logic rw, m2r, mr, mw, input logic [31:0] alu, sd, rdat,
    input logic erw, input logic [4:0] erd, input logic eld, emw,
    input logic [31:0] esd, input logic wrw, input logic [4:0] wrd,
    input logic [31:0] wd);
    vec_t r;
    r = '{st, fl, v, rd, rw, m2r, mr, mw, alu, sd, rdat,
          erw, erd, eld, emw, esd, wrw, wrd, wd};
    return r;
  endfunction

  task automatic drive(input logic st, fl, v, input logic [4:0] rd,
                       input logic rw, m2r, mr, mw,
                       input logic [31:0] alu, sd, rdat);
    stall = st; flush = fl; ex_valid = v; ex_rd = rd;
    ex_regwrite = rw; ex_memtoreg = m2r; ex_memread = mr;
    ex_memwrite = mw; ex_alu_result = alu; ex_store_data = sd;
    mem_rdata = rdat;
  endtask

  vec_t vt[14];

  initial begin
    vt[0]  = mk(0,0,1,8,1,0,0,0,32'hA5,0,0, 1,8,0,0,0, 0,0,0);
    vt[1]  = mk(0,0,1,9,1,1,1,0,32'h100,0,0, 1,9,1,0,0, 1,8,32'hA5);
    vt[2]  = mk(0,0,1,0,1,0,0,0,32'h77,0,32'hDEADBEEF,
                0,0,0,0,0, 1,9,32'hDEADBEEF);
    vt[3]  = mk(0,0,0,3,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    vt[4]  = mk(0,0,1,10,1,1,1,0,32'h200,0,0, 1,10,1,0,0, 0,0,0);
    vt[5]  = mk(1,0,1,11,1,0,0,0,32'h300,0,32'h1111, 1,10,1,0,0, 0,0,0);
    vt[6]  = mk(1,0,1,11,1,0,0,0,32'h300,0,32'h2222, 1,10,1,0,0, 0,0,0);
    vt[7]  = mk(0,0,1,12,1,0,0,0,32'hC0,0,32'hCAFEF00D,
                1,12,0,0,0, 1,10,32'hCAFEF00D);
    vt[8]  = mk(0,1,1,0,0,0,0,1,32'h400,32'h55,0, 0,0,0,0,0, 1,12,32'hC0);
    vt[9]  = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    vt[10] = mk(0,0,1,5,1,0,0,0,32'h55,0,0, 1,5,0,0,0, 0,0,0);
    vt[11] = mk(1,1,1,6,1,0,0,0,32'h66,0,0, 0,0,0,0,0, 0,0,0);
    vt[12] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    vt[13] = mk(0,0,1,0,0,0,0,1,32'h40,32'h1234,0,
                0,0,0,1,32'h1234, 0,0,0);

    rst_n = 1'b0;
    drive(0,0,0,0,0,0,0,0,0,0,0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset ex_mem_regwrite", {31'd0, ex_mem_regwrite}, 32'd0);
    chk("reset ex_mem_rd", {27'd0, ex_mem_rd}, 32'd0);
    chk("reset ex_mem_alu", ex_mem_alu_result, 32'd0);
    chk("reset mem_wb_regwrite", {31'd0, mem_wb_regwrite}, 32'd0);
    chk("reset mem_wb_wdata", mem_wb_wdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].st, vt[i].fl, vt[i].v, vt[i].rd, vt[i].rw, vt[i].m2r,
            vt[i].mr, vt[i].mw, vt[i].alu, vt[i].sd, vt[i].rdat);
      step();
      $display("vector %0d", i);
      chk("vec ex_mem_regwrite", {31'd0, ex_mem_regwrite}, {31'd0, vt[i].e_rw});
      chk("vec ex_mem_is_load", {31'd0, ex_mem_is_load}, {31'd0, vt[i].e_ld});
      chk("vec ex_mem_memwrite", {31'd0, ex_mem_memwrite}, {31'd0, vt[i].e_mw});
      chk("vec mem_wb_regwrite", {31'd0, mem_wb_regwrite}, {31'd0, vt[i].w_rw});
      if (vt[i].e_rw)
        chk("vec ex_mem_rd", {27'd0, ex_mem_rd}, {27'd0, vt[i].e_rd});
      if (vt[i].e_mw)
        chk("vec ex_mem_store", ex_mem_store_data, vt[i].e_sd);
      if (vt[i].w_rw) begin
        chk("vec mem_wb_rd", {27'd0, mem_wb_rd}, {27'd0, vt[i].w_rd});
        chk("vec mem_wb_wdata", mem_wb_wdata, vt[i].w_d);
      end
    end

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 4) != 0, 5'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom);
      step();
      model_check();
    end

    // Load both stages, then reset between edges.
    drive(0,0,1,7,1,0,0,0,32'h1234_5678,0,0);
    step();
    drive(0,0,1,14,1,1,1,0,32'h80,0,32'h0BAD_F00D);
    step();
    model_check();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst ex_mem_regwrite", {31'd0, ex_mem_regwrite}, 32'd0);
    chk("midrst ex_mem_is_load", {31'd0, ex_mem_is_load}, 32'd0);
    chk("midrst ex_mem_rd", {27'd0, ex_mem_rd}, 32'd0);
    chk("midrst ex_mem_alu", ex_mem_alu_result, 32'd0);
    chk("midrst mem_wb_regwrite", {31'd0, mem_wb_regwrite}, 32'd0);
    chk("midrst mem_wb_rd", {27'd0, mem_wb_rd}, 32'd0);
    chk("midrst mem_wb_wdata", mem_wb_wdata, 32'd0);
`ifdef RETIRE_COUNT_EN
    chk("midrst retire_cnt", retire_cnt, 32'd0);
`endif
    drive(0,0,0,0,0,0,0,0,0,0,0);
    rst_n = 1'b1;
    step();
    model_check();

    for (int i = 0; i < 100; i++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
            1'($urandom), 5'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom);
      step();
      model_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
- Holds the EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core.
- Produces the ex_mem_rd, ex_mem_regwrite, mem_wb_rd and mem_wb_regwrite qualifiers consumed by the forwarding unit, plus the forwarded data values and the write-back bus.
- Resolves the MEM-stage write-back mux (ALU result vs load data).
- Supports stall and flush so that bubbles never look like real register writes.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold EX/MEM contents; inject bubble into MEM/WB.
- flush  in  1  inject bubble into EX/MEM (branch/exception squash of the EX instruction).
- ex_valid  in  1  EX stage holds a real instruction.
- ex_rd  in  REG_AW  destination register from EX.
- ex_regwrite  in  1  EX instruction writes the register file.
- ex_memtoreg  in  1  write-back source is load data.
- ex_memread  in  1  load.
- ex_memwrite  in  1  store.
- ex_alu_result  in  DATA_W  ALU output / memory address.
- ex_store_data  in  DATA_W  forwarded rt value for stores.
- mem_rdata  in  DATA_W  data-memory read data (combinational on ex_mem_alu_result).
- ex_mem_rd  out  REG_AW  EX/MEM destination.
- ex_mem_regwrite  out  1  qualified EX/MEM write enable.
- ex_mem_alu_result  out  DATA_W  EX/MEM ALU result (address and forward value).
- ex_mem_store_data  out  DATA_W  store data to memory.
- ex_mem_memread  out  1  qualified load strobe.
- ex_mem_memwrite  out  1  qualified store strobe.
- ex_mem_is_load  out  1  valid load in EX/MEM, for hazard detection.
- mem_wb_rd  out  REG_AW  MEM/WB destination.
- mem_wb_regwrite  out  1  qualified MEM/WB write enable.
- mem_wb_wdata  out  DATA_W  write-back / forward value.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, so every output is 0, including both valid bits.
- EX/MEM update on each rising edge:
  - flush=1: valid<=0, all other fields hold their previous values. flush has priority over stall.
  - else stall=1: hold all fields.
  - else: capture every ex_* field; valid<=ex_valid.
- MEM/WB update on each rising edge:
  - stall=1: valid<=0 (bubble).
  - else: valid<=EX/MEM valid; rd<=EX/MEM rd; regwrite<=EX/MEM regwrite.
  - wdata<= mem_rdata if EX/MEM memtoreg, else EX/MEM alu_result.
- Qualification (combinational from registered state):
  - ex_mem_regwrite = valid & regwrite & (rd != 0).
  - mem_wb_regwrite is formed the same way from MEM/WB state.
  - ex_mem_memread = valid & memread; ex_mem_memwrite = valid & memwrite.
  - ex_mem_is_load = ex_mem_memread & (rd != 0).
  - A write to $zero is never reported, so the forwarder needs no zero check.
- Latency: an instruction in EX at edge N appears on ex_mem_* after edge N and on mem_wb_* after edge N+1. Each stall cycle adds one cycle.
- Data outputs are undefined when the matching regwrite or strobe is 0. Bench checks data only when qualified.
- Simultaneous flush and stall: EX/MEM invalidated, MEM/WB gets a bubble.
- Reset mid-operation clears both stages immediately, with no partial write-back.
- No wrap or overflow conditions: pure registers.

Optional Feature:
- Macro RETIRE_COUNT_EN.
- When defined, adds output retire_cnt [31:0]:
  - increments by 1 on each edge where MEM/WB holds a valid instruction (any type, including stores and nops marked valid);
  - wraps 0xFFFFFFFF -> 0;
  - cleared by rst_n.
- When undefined, the port and counter are absent.

Test Plan:
- Reset: rst_n=0 mid-stream with valid data loaded -> all outputs 0 immediately, before any clock edge.
- ALU op: ex_valid=1, rd=8, regwrite=1, alu=0x0000_00A5 -> next cycle ex_mem_rd=8, ex_mem_regwrite=1; cycle after, mem_wb_rd=8, mem_wb_wdata=0xA5, mem_wb_regwrite=1.
- Load: memtoreg=1, memread=1, rd=9, alu=0x100, mem_rdata=0xDEAD_BEEF -> ex_mem_is_load=1 for one cycle; then mem_wb_wdata=0xDEADBEEF.
- $zero: rd=0, regwrite=1 -> ex_mem_regwrite=0 and mem_wb_regwrite=0 throughout.
- Stall: load in EX/MEM, stall=1 for 2 cycles -> EX/MEM fields held; mem_wb_regwrite=0 for 2 cycles; the load reaches WB one cycle after stall drops.
- Flush: flush=1 with a valid store (memwrite=1) in EX -> ex_mem_memwrite=0 next cycle, and no write reaches mem_wb.
